// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative signed multiply/divide sequencer.
package mult_div_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // Iteration counter width: log2(WIDTH)+1 bits, so the counter can hold WIDTH itself.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MULT_CALC = 3'd1,
      DIV_CALC  = 3'd2,
      FIX_SIGN  = 3'd3,
      DONE      = 3'd4
   } state_t;

endpackage

// File: rtl/mult_div_sequencer_if.sv
// Handshake and result bus between the control unit (master) and the sequencer (slave).
interface mult_div_sequencer_if #(parameter int WIDTH = mult_div_pkg::DEFAULT_WIDTH);

   logic             start_mult;
   logic             start_div;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             busy;
   logic             done;
   logic             div0;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start_mult, start_div, operand_a, operand_b,
      input  busy, done, div0, hi, lo
   );

   modport slave (
      input  start_mult, start_div, operand_a, operand_b,
      output busy, done, div0, hi, lo
   );

endinterface

// File: rtl/twos_negate.sv
// Conditional two's-complement negate: passes the input through, or negates it when neg_i is set.
module twos_negate #(
   parameter int W = 32
) (
   input  logic [W-1:0] din_i,
   input  logic         neg_i,
   output logic [W-1:0] dout_o
);

   assign dout_o = neg_i ? (~din_i + W'(1)) : din_i;

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative signed multiply/divide: magnitudes are processed one bit per cycle by
// shift-add (multiply) or restoring division, then the sign is applied and HI/LO updated.
module mult_div_sequencer
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset,
   mult_div_sequencer_if.slave  bus
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   // Multiplicand for multiply, divisor for divide (always a magnitude).
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic                 neg_res_q, neg_res_d;
   logic                 neg_rem_q, neg_rem_d;
   logic                 is_div_q, is_div_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 div0_q, div0_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [2*WIDTH-1:0]   prod_signed;
   logic [WIDTH-1:0]     quo_signed, rem_signed;

   logic [WIDTH:0]       madd;
   logic [2*WIDTH-1:0]   mult_next;
   logic [WIDTH:0]       dtrial;
   logic [WIDTH-1:0]     rem_next;
   logic [2*WIDTH-1:0]   div_next;

   twos_negate #(.W(WIDTH)) u_abs_a (
      .din_i (bus.operand_a),
      .neg_i (bus.operand_a[WIDTH-1]),
      .dout_o(abs_a)
   );

   twos_negate #(.W(WIDTH)) u_abs_b (
      .din_i (bus.operand_b),
      .neg_i (bus.operand_b[WIDTH-1]),
      .dout_o(abs_b)
   );

   twos_negate #(.W(2*WIDTH)) u_fix_prod (
      .din_i (acc_q),
      .neg_i (neg_res_q),
      .dout_o(prod_signed)
   );

   twos_negate #(.W(WIDTH)) u_fix_quo (
      .din_i (acc_q[WIDTH-1:0]),
      .neg_i (neg_res_q),
      .dout_o(quo_signed)
   );

   twos_negate #(.W(WIDTH)) u_fix_rem (
      .din_i (acc_q[2*WIDTH-1:WIDTH]),
      .neg_i (neg_rem_q),
      .dout_o(rem_signed)
   );

   // One shift-add step and one restoring-division step over the current accumulator.
   always_comb begin
      madd      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mult_next = {madd, acc_q[WIDTH-1:1]};
      dtrial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
      rem_next  = dtrial[WIDTH] ? acc_q[2*WIDTH-2:WIDTH-1] : dtrial[WIDTH-1:0];
      div_next  = {rem_next, acc_q[WIDTH-2:0], ~dtrial[WIDTH]};
   end

   // Next-state and datapath update for the sequencing FSM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      is_div_d  = is_div_q;
      done_d    = 1'b0;
      div0_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         IDLE: begin
            if (bus.start_mult || (bus.start_div && (bus.operand_b != '0))) begin
               acc_d     = {{WIDTH{1'b0}}, abs_a};
               opb_d     = abs_b;
               neg_res_d = bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
               neg_rem_d = bus.operand_a[WIDTH-1];
               cnt_d     = '0;
               is_div_d  = !bus.start_mult;
               state_d   = bus.start_mult ? MULT_CALC : DIV_CALC;
            end else if (bus.start_div) begin
               // Divide by zero: flag it and stay idle with HI/LO untouched.
               div0_d = 1'b1;
            end
         end
         MULT_CALC: begin
            acc_d = mult_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX_SIGN;
         end
         DIV_CALC: begin
            acc_d = div_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX_SIGN;
         end
         FIX_SIGN: begin
            if (is_div_q) begin
               hi_d = rem_signed;
               lo_d = quo_signed;
            end else begin
               hi_d = prod_signed[2*WIDTH-1:WIDTH];
               lo_d = prod_signed[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, datapath and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_div_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         is_div_q  <= is_div_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.div0 = div0_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Randomised self-checking bench for mult_div_sequencer against a plain-arithmetic model.
module tb_mult_div_sequencer;

   localparam int W = 32;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   mult_div_sequencer_if #(.WIDTH(W)) bus ();

   mult_div_sequencer #(.WIDTH(W)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Signed reference: 64-bit product, truncating division with remainder sign of dividend.
   task automatic ref_model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] hi, output logic [W-1:0] lo);
      longint sa;
      longint sb;
      longint p;
      longint q;
      longint r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!is_div) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         hi = r[31:0];
         lo = q[31:0];
      end
   endtask

   // Issue one operation and follow it cycle by cycle; inj_cyc > 0 injects a start_div then.
   task automatic run_op(input string tag, input bit sm, input bit sd,
                         input logic [W-1:0] a, input logic [W-1:0] b, input int inj_cyc);
      logic [W-1:0] new_hi, new_lo;
      int done_cyc;
      int done_cnt;
      bit busy_bad;
      bit div0_seen;
      ref_model(sd && !sm, a, b, new_hi, new_lo);
      @(negedge clock);
      bus.start_mult = sm;
      bus.start_div  = sd;
      bus.operand_a  = a;
      bus.operand_b  = b;
      done_cyc  = -1;
      done_cnt  = 0;
      busy_bad  = 1'b0;
      div0_seen = 1'b0;
      for (int c = 1; c <= W + 5; c++) begin
         @(negedge clock);
         if (c == 1) begin
            bus.start_mult = 1'b0;
            bus.start_div  = 1'b0;
            bus.operand_a  = $urandom;
            bus.operand_b  = $urandom;
         end
         if (c == inj_cyc + 1) bus.start_div = 1'b0;
         if (c <= W + 2 && !bus.busy) busy_bad = 1'b1;
         if (c >= W + 3 && bus.busy) busy_bad = 1'b1;
         if (bus.div0) div0_seen = 1'b1;
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c == W + 1) begin
            check({tag, " hi_before_done"}, 64'(bus.hi), 64'(exp_hi));
            check({tag, " lo_before_done"}, 64'(bus.lo), 64'(exp_lo));
         end
         if (c == W + 2) begin
            check({tag, " hi"}, 64'(bus.hi), 64'(new_hi));
            check({tag, " lo"}, 64'(bus.lo), 64'(new_lo));
         end
         if (inj_cyc > 0 && c == inj_cyc) begin
            bus.start_div = 1'b1;
            bus.operand_b = $urandom;
         end
      end
      check({tag, " done_cycle"}, 64'(done_cyc), 64'(W + 2));
      check({tag, " done_count"}, 64'(done_cnt), 64'd1);
      check({tag, " busy_window_bad"}, 64'(busy_bad), 64'd0);
      check({tag, " div0_seen"}, 64'(div0_seen), 64'd0);
      exp_hi = new_hi;
      exp_lo = new_lo;
   endtask

   // Divide by zero: div0 in cycle 1 only, never busy or done, HI/LO untouched.
   task automatic run_div0(input string tag, input logic [W-1:0] a);
      bit bad;
      @(negedge clock);
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b1;
      bus.operand_a  = a;
      bus.operand_b  = '0;
      @(negedge clock);
      bus.start_div = 1'b0;
      check({tag, " div0_cycle1"}, 64'(bus.div0), 64'd1);
      check({tag, " busy_cycle1"}, 64'(bus.busy), 64'd0);
      bad = 1'b0;
      for (int c = 2; c <= 8; c++) begin
         @(negedge clock);
         if (bus.div0 || bus.busy || bus.done) bad = 1'b1;
      end
      check({tag, " quiet_after"}, 64'(bad), 64'd0);
      check({tag, " hi_kept"}, 64'(bus.hi), 64'(exp_hi));
      check({tag, " lo_kept"}, 64'(bus.lo), 64'(exp_lo));
   endtask

   // Reset in cycle 10 of a multiply: immediate return to reset state, no done or div0 later.
   task automatic run_reset_abort(input logic [W-1:0] a, input logic [W-1:0] b);
      bit bad;
      @(negedge clock);
      bus.start_mult = 1'b1;
      bus.operand_a  = a;
      bus.operand_b  = b;
      @(negedge clock);
      bus.start_mult = 1'b0;
      for (int c = 2; c <= 10; c++) @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst_abort busy", 64'(bus.busy), 64'd0);
      check("rst_abort hi", 64'(bus.hi), 64'd0);
      check("rst_abort lo", 64'(bus.lo), 64'd0);
      check("rst_abort done", 64'(bus.done), 64'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < W + 6; c++) begin
         @(negedge clock);
         if (bus.done || bus.div0 || bus.busy) bad = 1'b1;
      end
      check("rst_abort no_done", 64'(bad), 64'd0);
      exp_hi = '0;
      exp_lo = '0;
   endtask

   logic [W-1:0] edge_vals [6];
   logic [W-1:0] ra, rb;
   int kind;

   initial begin
      edge_vals[0] = 32'h0000_0000;
      edge_vals[1] = 32'h0000_0001;
      edge_vals[2] = 32'hFFFF_FFFF;
      edge_vals[3] = 32'h8000_0000;
      edge_vals[4] = 32'h7FFF_FFFF;
      edge_vals[5] = 32'h0000_0002;

      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      bus.operand_a  = '0;
      bus.operand_b  = '0;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(negedge clock);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset div0", 64'(bus.div0), 64'd0);
      check("reset hi", 64'(bus.hi), 64'd0);
      check("reset lo", 64'(bus.lo), 64'd0);
      reset = 1'b1;

      run_op("mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
      check("mul_7x-3 hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
      check("mul_7x-3 lo_const", 64'(bus.lo), 64'hFFFF_FFEB);
      run_op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
      check("mul_min_min hi_const", 64'(bus.hi), 64'h4000_0000);
      run_op("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
      check("div_-7/2 lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
      run_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("div_min/-1 lo_const", 64'(bus.lo), 64'h8000_0000);
      run_div0("div0_5", 32'd5);
      run_op("both_starts", 1'b1, 1'b1, 32'd6, 32'd4, 5);
      check("both_starts lo_const", 64'(bus.lo), 64'd24);
      run_reset_abort($urandom, $urandom);
      run_op("mul_3x3", 1'b1, 1'b0, 32'd3, 32'd3, 0);
      check("mul_3x3 lo_const", 64'(bus.lo), 64'd9);

      for (int i = 0; i < 24; i++) begin
         ra = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : 32'($urandom);
         rb = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : 32'($urandom);
         kind = $urandom_range(0, 1);
         if (kind == 0) begin
            run_op("rand_mul", 1'b1, 1'b0, ra, rb, 0);
         end else if (rb == '0) begin
            run_div0("rand_div0", ra);
         end else begin
            run_op("rand_div", 1'b0, 1'b1, ra, rb, ($urandom_range(0, 1) == 1) ? 7 : 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mult_div_sequencer.md
# mult_div_sequencer

Iterative signed multiply/divide engine with its own sequencing FSM. It serves the control unit's MULT and DIV instructions: it accepts a one-cycle start, runs WIDTH shift iterations, then updates the HI/LO result registers. The control unit holds in its MULT_CALC/DIV_CALC states until `done`, or branches to its DIVZERO exception path on `div0`.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-low; low forces the block to its reset state.
- `start_mult`, in, 1: one-cycle request for a signed multiply of `operand_a` × `operand_b`.
- `start_div`, in, 1: one-cycle request for a signed divide, `operand_a` ÷ `operand_b`.
- `operand_a`, in, WIDTH: rs value, sampled only on an accepted start.
- `operand_b`, in, WIDTH: rt value, sampled only on an accepted start.
- `busy`, out, 1: high while an operation is in flight (all states except IDLE).
- `done`, out, 1: one-cycle pulse; HI/LO carry the new result in that same cycle.
- `div0`, out, 1: one-cycle pulse flagging a divide by zero.
- `hi`, out, WIDTH: HI register (product upper half, or remainder).
- `lo`, out, WIDTH: LO register (product lower half, or quotient).

## Operation
- Reset state: FSM in IDLE; `busy`, `done` and `div0` are 0; `hi` and `lo` are 0; internal counters and shift registers are cleared.
- States are IDLE, MULT_CALC, DIV_CALC, FIX_SIGN and DONE.
- IDLE:
  - A start is accepted only in IDLE.
  - If `start_mult` and `start_div` are both high, the multiply wins.
  - On an accepted start: latch the magnitudes |a| and |b|, latch the result-sign flags, clear the iteration counter, then move to MULT_CALC or DIV_CALC.
  - `start_div` with `operand_b == 0`:
    - stay in IDLE;
    - pulse `div0` in the next cycle;
    - leave HI/LO unchanged;
    - never assert `done`.
- MULT_CALC: unsigned shift-add over the magnitudes, one bit per cycle, building a 2×WIDTH product. After iteration WIDTH-1, move to FIX_SIGN.
- DIV_CALC: unsigned restoring division, one quotient bit per cycle. After iteration WIDTH-1, move to FIX_SIGN.
- FIX_SIGN, multiply:
  - negate the 2×WIDTH product if sign(a) XOR sign(b);
  - HI ← upper half, LO ← lower half.
- FIX_SIGN, divide:
  - negate the quotient if the operand signs differ;
  - the remainder takes the sign of the dividend;
  - LO ← quotient, HI ← remainder.
  - HI and LO are registered on the transition into DONE.
- DONE: assert `done` for exactly one cycle, then return to IDLE.
- Starts arriving while `busy` is high are ignored and are not queued.
- Arithmetic:
  - Magnitudes are WIDTH-bit unsigned, so |−2^(WIDTH−1)| is represented exactly.
  - −2^31 ÷ −1 yields LO = 0x80000000, HI = 0; no overflow flag is raised.
- HI/LO change only when entering DONE, or on reset.

## Timing
- If a start is accepted at the edge ending cycle 0:
  - cycles 1 to WIDTH are spent in CALC;
  - cycle WIDTH+1 is FIX_SIGN;
  - cycle WIDTH+2 is DONE (cycle 34 for WIDTH = 32).
- `busy` goes high in cycle 1 and drops in cycle WIDTH+3.
- A new start can therefore be accepted in cycle WIDTH+3 at the earliest.
- `div0` is asserted in cycle 1; `busy` stays 0 throughout.
- Reset asserted mid-operation: an immediate return to the reset state. The aborted operation produces no `done` and no `div0`.
- All outputs are driven from registers; there are no combinational paths from the inputs.

## Structure
- Package `mult_div_pkg` holds:
  - the state enum (IDLE, MULT_CALC, DIV_CALC, FIX_SIGN, DONE);
  - the default width constant;
  - the iteration-count width, log2(WIDTH)+1.
- One sub-module, `twos_negate`: a parameterised conditional two's-complement negate. It is reused for operand magnitude extraction and for sign correction in FIX_SIGN.

## Test plan
- Multiply 7 × −3 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; `done` in cycle 34; `busy` high for cycles 1 to 34.
- Multiply 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0x00000000.
- Divide −7 ÷ 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- Divide 0x80000000 ÷ 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Divide 5 ÷ 0 → `div0` pulses in cycle 1; `busy` stays 0; HI/LO keep their prior values; no `done`.
- Busy, simultaneous-start and reset cases:
  - start with `start_mult` and `start_div` both high (6, 4) → multiply result HI = 0, LO = 24;
  - a `start_div` in cycle 5 is ignored;
  - drive `reset` low in cycle 10 of a fresh multiply → `busy` = 0 and HI = LO = 0, with no `done`;
  - a following 3 × 3 → LO = 9.
